number_entry: RTL and testbench
===============================

// Module: number_entry
// PURPOSE
//  Upstream front end for the palindrome checker. Accumulates decimal digits (one per
//  valid beat, MSD first) into a 32-bit binary number, then on enter presents it
//  stable on number_o with a one-cycle go_o pulse. Holds the value until the checker
//  reports done_i (or a timeout expires), then re-arms for the next number.
// PARAMETERS
//  MAX_DIGITS    10     max accepted digits (1..10); further digits rejected
//  DONE_TIMEOUT  64     cycles to wait for done_i after go_o before forced re-arm
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  digit_i        in   4   decimal digit, sampled when digit_valid_i=1
//  digit_valid_i  in   1   digit strobe
//  backspace_i    in   1   remove last digit (number_o <= number_o/10)
//  enter_i        in   1   submit accumulated number
//  clear_i        in   1   discard entry, clear error
//  done_i         in   1   downstream finished with number_o
//  number_o       out  32  accumulated / submitted value
//  digit_count_o  out  4   digits currently held
//  go_o           out  1   one-cycle submit pulse
//  busy_o         out  1   1 in ISSUE and WAIT; inputs other than clear_i ignored
//  error_o        out  1   sticky: rejected digit, overflow or timeout
//  timeout_o      out  1   one-cycle pulse when DONE_TIMEOUT expires
// BEHAVIOUR
//  Reset: state=ENTRY; number_o=0, digit_count_o=0, go_o=0, busy_o=0, error_o=0,
//   timeout_o=0, timer=0. reset overrides everything, including mid-WAIT.
//  States: ENTRY -> ISSUE -> WAIT -> ENTRY.
//  ENTRY, per-cycle priority: clear_i > enter_i > backspace_i > digit_valid_i.
//   clear_i: number_o=0, count=0, error_o=0 next cycle.
//   enter_i: count==0 -> ignored, stay ENTRY; else -> ISSUE.
//   backspace_i: count>0 -> number_o=number_o/10, count-1; count==0 -> no-op.
//   digit: compute n = number_o*10 + digit_i in 36 bits. Reject (state unchanged,
//    error_o=1) if digit_i>9, count==MAX_DIGITS, or n>32'hFFFF_FFFF; else
//    number_o=n[31:0], count+1. Leading zeros count as digits (value unchanged).
//  ISSUE: go_o=1 for exactly this one cycle, busy_o=1, timer=0; -> WAIT.
//  WAIT: busy_o=1, number_o held stable; timer increments each cycle.
//   done_i=1 -> ENTRY with number_o=0, count=0 (error_o unchanged).
//   timer reaches DONE_TIMEOUT-1 without done_i -> timeout_o pulse, error_o=1,
//    -> ENTRY, number_o=0, count=0. done_i and expiry same cycle: done wins.
//   clear_i in ISSUE/WAIT -> ENTRY, number_o=0, count=0, error_o=0, no timeout.
//  done_i outside WAIT ignored. Digit/enter/backspace while busy_o=1 dropped.
//  go_o latency: enter_i sampled at edge N -> go_o high during cycle N+1 only.
//  All outputs registered; no combinational input-to-output paths.
// TESTING
//  digits 1,2,3,2,1 then enter -> number_o=12321, count=5, go_o one cycle after enter;
//   done_i 3 cycles later -> busy_o falls, number_o=0.
//  digits 4,2,9,4,9,6,7,2,9,5 -> number_o=4294967295; next digit 0 -> rejected,
//   error_o=1, number_o unchanged; clear_i -> error_o=0, number_o=0.
//  digits 4,2,9,4,9,6,7,2,9,6 -> tenth digit rejected (overflow), number_o=429496729.
//  digits 7,8,9, backspace, backspace, digit 5 -> number_o=75, count=2; digit 4'hA -> error.
//  enter with count=0 -> no go_o; enter, no done_i -> timeout_o at go+DONE_TIMEOUT,
//   error_o=1, state ENTRY.
//  reset asserted in WAIT with enter_i and digit_valid_i high -> all outputs reset values.

Source files
------------

// File: rtl/number_entry.sv
// rtl/number_entry.sv - decimal digit entry front end for the palindrome checker
//
// Purpose: accumulates decimal digits (MSD first) into a 32-bit binary value.
// On enter it presents the value on number_o with a one-cycle go_o pulse. It then
// holds the value until done_i or a timeout, and re-arms for the next number.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high
//   digit_i        in   4   decimal digit, sampled when digit_valid_i=1
//   digit_valid_i  in   1   digit strobe
//   backspace_i    in   1   remove last digit (value / 10)
//   enter_i        in   1   submit accumulated number
//   clear_i        in   1   discard entry, clear error
//   done_i         in   1   downstream finished with number_o
//   number_o       out  32  accumulated / submitted value
//   digit_count_o  out  4   digits currently held
//   go_o           out  1   one-cycle submit pulse
//   busy_o         out  1   high while a number is issued and awaiting done_i
//   error_o        out  1   sticky: rejected digit, overflow or timeout
//   timeout_o      out  1   one-cycle pulse when the done_i wait expires
module number_entry #(
  parameter int unsigned MAX_DIGITS   = 10,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_i,
  input  logic        digit_valid_i,
  input  logic        backspace_i,
  input  logic        enter_i,
  input  logic        clear_i,
  input  logic        done_i,
  output logic [31:0] number_o,
  output logic [3:0]  digit_count_o,
  output logic        go_o,
  output logic        busy_o,
  output logic        error_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int unsigned TIMER_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DONE_TIMEOUT - 1);
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t              state_q, state_d;
  logic [31:0]         number_q, number_d;
  logic [3:0]          count_q, count_d;
  logic                error_q, error_d;
  logic                timeout_q, timeout_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;

  // number*10 + digit, kept 36 bits wide so overflow past 32 bits is visible
  logic [35:0] next_value;
  logic [31:0] shortened;

  always_comb begin
    next_value = ({4'd0, number_q} << 3) + ({4'd0, number_q} << 1) + {32'd0, digit_i};
    shortened  = number_q / 32'd10;
  end

  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    count_d   = count_q;
    error_d   = error_q;
    timeout_d = 1'b0;
    timer_d   = timer_q;

    case (state_q)
      ST_ENTRY: begin
        if (clear_i) begin
          number_d = 32'd0;
          count_d  = 4'd0;
          error_d  = 1'b0;
        end else if (enter_i) begin
          if (count_q != 4'd0) begin
            state_d = ST_ISSUE;
          end
        end else if (backspace_i) begin
          if (count_q != 4'd0) begin
            number_d = shortened;
            count_d  = count_q - 4'd1;
          end
        end else if (digit_valid_i) begin
          if ((digit_i > 4'd9) || (count_q >= MAX_CNT) || (next_value[35:32] != 4'd0)) begin
            error_d = 1'b1;
          end else begin
            number_d = next_value[31:0];
            count_d  = count_q + 4'd1;
          end
        end
      end

      ST_ISSUE: begin
        timer_d = '0;
        if (clear_i) begin
          state_d  = ST_ENTRY;
          number_d = 32'd0;
          count_d  = 4'd0;
          error_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (clear_i) begin
          state_d  = ST_ENTRY;
          number_d = 32'd0;
          count_d  = 4'd0;
          error_d  = 1'b0;
        end else if (done_i) begin
          state_d  = ST_ENTRY;
          number_d = 32'd0;
          count_d  = 4'd0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
          // Expiry is decided as the timer steps onto its last value so the
          // timeout pulse lands DONE_TIMEOUT cycles after go_o.
          if (timer_d == TIMER_LAST) begin
            state_d   = ST_ENTRY;
            number_d  = 32'd0;
            count_d   = 4'd0;
            error_d   = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_ENTRY;
      number_q  <= 32'd0;
      count_q   <= 4'd0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      number_q  <= number_d;
      count_q   <= count_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      timer_q   <= timer_d;
    end
  end

  assign number_o      = number_q;
  assign digit_count_o = count_q;
  assign go_o          = (state_q == ST_ISSUE);
  assign busy_o        = (state_q != ST_ENTRY);
  assign error_o       = error_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_number_entry.sv
// tb/tb_number_entry.sv - self-checking bench for number_entry
module tb_number_entry;

  localparam int MAXD = 10;
  localparam int DT   = 64;

  localparam int PH_ENTRY = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;

  logic        clock;
  logic        reset;
  logic [3:0]  digit_i;
  logic        digit_valid_i;
  logic        backspace_i;
  logic        enter_i;
  logic        clear_i;
  logic        done_i;
  logic [31:0] number_o;
  logic [3:0]  digit_count_o;
  logic        go_o;
  logic        busy_o;
  logic        error_o;
  logic        timeout_o;

  number_entry #(.MAX_DIGITS(MAXD), .DONE_TIMEOUT(DT)) dut (
    .clock         (clock),
    .reset         (reset),
    .digit_i       (digit_i),
    .digit_valid_i (digit_valid_i),
    .backspace_i   (backspace_i),
    .enter_i       (enter_i),
    .clear_i       (clear_i),
    .done_i        (done_i),
    .number_o      (number_o),
    .digit_count_o (digit_count_o),
    .go_o          (go_o),
    .busy_o        (busy_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the entered value as a plain integer plus the phase of
  // the submit handshake and the number of cycles elapsed since go.
  longint m_num;
  int     m_cnt;
  bit     m_err;
  bit     m_to;
  int     phase;
  int     since_go;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_entry();
    phase = PH_ENTRY;
    m_num = 0;
    m_cnt = 0;
  endtask

  task automatic model_update(input bit rst, input int d, input bit dv, input bit bs,
                              input bit en, input bit clr, input bit dn);
    longint n;
    m_to = 0;
    if (rst) begin
      model_clear_entry();
      m_err    = 0;
      since_go = 0;
    end else if (phase == PH_ENTRY) begin
      if (clr) begin
        model_clear_entry();
        m_err = 0;
      end else if (en) begin
        if (m_cnt > 0) phase = PH_ISSUE;
      end else if (bs) begin
        if (m_cnt > 0) begin
          m_num = m_num / 10;
          m_cnt = m_cnt - 1;
        end
      end else if (dv) begin
        n = m_num * 10 + d;
        if (d > 9 || m_cnt == MAXD || n > 64'd4294967295) m_err = 1;
        else begin
          m_num = n;
          m_cnt = m_cnt + 1;
        end
      end
    end else if (phase == PH_ISSUE) begin
      if (clr) begin
        model_clear_entry();
        m_err = 0;
      end else begin
        phase    = PH_WAIT;
        since_go = 1;
      end
    end else begin
      if (clr) begin
        model_clear_entry();
        m_err = 0;
      end else if (dn) begin
        model_clear_entry();
      end else if (since_go == DT - 1) begin
        // the cycle after this one is DT cycles after go
        model_clear_entry();
        m_err = 1;
        m_to  = 1;
      end else begin
        since_go++;
      end
    end
  endtask

  task automatic step(input bit rst, input int d, input bit dv, input bit bs,
                      input bit en, input bit clr, input bit dn);
    reset         = rst;
    digit_i       = 4'(d);
    digit_valid_i = dv;
    backspace_i   = bs;
    enter_i       = en;
    clear_i       = clr;
    done_i        = dn;
    @(posedge clock);
    #1;
    model_update(rst, d, dv, bs, en, clr, dn);
    check("number", number_o, m_num);
    check("count", digit_count_o, m_cnt);
    check("go", go_o, (phase == PH_ISSUE) ? 1 : 0);
    check("busy", busy_o, (phase != PH_ENTRY) ? 1 : 0);
    check("error", error_o, m_err);
    check("timeout", timeout_o, m_to);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic key(input int d);
    step(0, d, 1, 0, 0, 0, 0);
  endtask

  task automatic key_seq(input int s[$]);
    foreach (s[i]) key(s[i]);
  endtask

  int got;
  int r;
  int dgt;

  initial begin
    m_num = 0; m_cnt = 0; m_err = 0; m_to = 0; phase = PH_ENTRY; since_go = 0;
    reset = 1; digit_i = 0; digit_valid_i = 0; backspace_i = 0;
    enter_i = 0; clear_i = 0; done_i = 0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("reset_number", number_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_error", error_o, 0);

    // palindrome 12321: go one cycle after enter, done three cycles later
    key_seq('{1, 2, 3, 2, 1});
    check("p_count", digit_count_o, 5);
    step(0, 0, 0, 0, 1, 0, 0);
    check("p_go", go_o, 1);
    check("p_number", number_o, 12321);
    idle();
    check("p_go_once", go_o, 0);
    check("p_busy", busy_o, 1);
    idle();
    step(0, 0, 0, 0, 0, 0, 1);
    check("p_done_busy", busy_o, 0);
    check("p_done_number", number_o, 0);

    // full 32-bit range, eleventh digit rejected, then clear
    key_seq('{4, 2, 9, 4, 9, 6, 7, 2, 9, 5});
    check("max_number", number_o, 64'd4294967295);
    key(0);
    check("max_reject_err", error_o, 1);
    check("max_reject_num", number_o, 64'd4294967295);
    step(0, 0, 0, 0, 0, 1, 0);
    check("clear_err", error_o, 0);
    check("clear_num", number_o, 0);

    // overflow on the tenth digit
    key_seq('{4, 2, 9, 4, 9, 6, 7, 2, 9, 6});
    check("ovf_number", number_o, 429496729);
    check("ovf_err", error_o, 1);
    step(0, 0, 0, 0, 0, 1, 0);

    // backspace and a non-decimal digit
    key_seq('{7, 8, 9});
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    key(5);
    check("bs_number", number_o, 75);
    check("bs_count", digit_count_o, 2);
    key(10);
    check("hex_err", error_o, 1);
    check("hex_number", number_o, 75);
    step(0, 0, 0, 0, 0, 1, 0);

    // empty enter ignored, then timeout with no done_i
    step(0, 0, 0, 0, 1, 0, 0);
    check("empty_enter_go", go_o, 0);
    key(3);
    step(0, 0, 0, 0, 1, 0, 0);
    check("to_go", go_o, 1);
    got = -1;
    for (int i = 1; i <= 3 * DT; i++) begin
      idle();
      if (timeout_o) begin
        got = i;
        break;
      end
    end
    check("to_latency", got, DT);
    check("to_err", error_o, 1);
    check("to_busy", busy_o, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // reset in WAIT with enter and digit strobes active
    key(8);
    step(0, 0, 0, 0, 1, 0, 0);
    idle();
    idle();
    step(1, 4, 1, 0, 1, 0, 0);
    check("rst_wait_number", number_o, 0);
    check("rst_wait_busy", busy_o, 0);
    check("rst_wait_go", go_o, 0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      r   = $urandom_range(0, 999);
      dgt = ($urandom_range(0, 11) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      step(r < 4, dgt, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
